// File: rtl/calc_display_pkg.sv
// Shared constants and types for the calculator display path.
// Used by the binary-to-BCD converter and the display digit rotator.
package calc_display_pkg;

    localparam int          DIGITS    = 8;
    localparam int          BCD_W     = 4;
    localparam int          ACC_W     = DIGITS * BCD_W;
    localparam logic [31:0] MAX_DEC   = 32'd99_999_999;
    localparam logic [3:0]  ERR_DIGIT = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/bin_to_bcd8_if.sv
// Request/result bundle between the arithmetic core and the BCD converter.
// The master side issues conversions; the slave side is the converter.
interface bin_to_bcd8_if
    import calc_display_pkg::*;
#(
    parameter int WIDTH = 27
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [BCD_W-1:0] digit0;
    logic [BCD_W-1:0] digit1;
    logic [BCD_W-1:0] digit2;
    logic [BCD_W-1:0] digit3;
    logic [BCD_W-1:0] digit4;
    logic [BCD_W-1:0] digit5;
    logic [BCD_W-1:0] digit6;
    logic [BCD_W-1:0] digit7;

    modport master (
        output start, value,
        input  busy, done, overflow,
        input  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7
    );

    modport slave (
        input  start, value,
        output busy, done, overflow,
        output digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7
    );

endinterface

// File: rtl/bin_to_bcd8_add3.sv
// Nibble adjust for double-dabble: a digit of 5 or more gets +3 before the shift,
// so it carries correctly into the next decimal position.
module bcd_add3
    import calc_display_pkg::*;
(
    input  logic [BCD_W-1:0] nib_i,
    output logic [BCD_W-1:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_bcd8.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
// Results are held in output registers between conversions so the display never tears.
module bin_to_bcd8
    import calc_display_pkg::*;
#(
    parameter int WIDTH = 27
)(
    input  logic          clk,
    input  logic          rst_n,
    bin_to_bcd8_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t                  state_q, state_d;
    logic [WIDTH-1:0]             shreg_q, shreg_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ovf_pend_q, ovf_pend_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         overflow_q, overflow_d;
    logic [DIGITS-1:0][BCD_W-1:0] digits_q, digits_d;
    logic [ACC_W-1:0]             acc_adj_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (acc_q[g*BCD_W +: BCD_W]),
            .nib_o (acc_adj_s[g*BCD_W +: BCD_W])
        );
    end

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        digits_d   = digits_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    shreg_d    = bus.value;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(bus.value) > MAX_DEC);
                    busy_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // The accumulator MSB falls off; overflow was already decided at load.
                acc_d   = {acc_adj_s[ACC_W-2:0], shreg_q[WIDTH-1]};
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                overflow_d = ovf_pend_q;
                if (ovf_pend_q) begin
                    digits_d = {DIGITS{ERR_DIGIT}};
                end else begin
                    digits_d = acc_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.digit0   = digits_q[0];
    assign bus.digit1   = digits_q[1];
    assign bus.digit2   = digits_q[2];
    assign bus.digit3   = digits_q[3];
    assign bus.digit4   = digits_q[4];
    assign bus.digit5   = digits_q[5];
    assign bus.digit6   = digits_q[6];
    assign bus.digit7   = digits_q[7];

endmodule
